bht_gshare: RTL and testbench
=============================

BHT_GSHARE -- requirements
Module: bht_gshare

Interface
REQ-001 Parameter IDX_W, default 5, sets the table index width; depth is 2^IDX_W entries.
REQ-002 Parameter CNT_W, default 2, sets the saturating counter width; legal range 1..4.
REQ-003 Parameter GHR_W, default 0, sets the global history width; 0 = bimodal mode, 1..IDX_W = gshare mode.
REQ-004 clk  input  1  single clock; all state rises on posedge clk.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 rd_valid  input  1  prediction lookup request this cycle.
REQ-007 rd_idx  input  IDX_W  lookup index, the low PC bits above instruction alignment.
REQ-008 pred_valid  output  1  pred_* fields valid, one cycle after rd_valid.
REQ-009 pred_taken  output  1  predicted direction.
REQ-010 pred_ctr  output  CNT_W  counter value the prediction was drawn from.
REQ-011 pred_tidx  output  IDX_W  hashed table index used; the caller returns it on update.
REQ-012 upd_valid  input  1  resolved-branch update request.
REQ-013 upd_tidx  input  IDX_W  table index to update, taken from pred_tidx.
REQ-014 upd_taken  input  1  resolved direction.
REQ-015 clr  input  1  synchronous reinitialisation of table and history.

Function
REQ-016 Storage SHALL be a flop array of 2^IDX_W counters, each CNT_W bits, with one read port and one write port.
REQ-017 Hashed index SHALL be rd_idx in bimodal mode, and rd_idx XOR zero-extended GHR in gshare mode.
REQ-018 On a posedge with rd_valid=1, pred_valid SHALL go to 1 and pred_* SHALL load; latency is exactly 1 cycle.
REQ-019 On a posedge with rd_valid=0, pred_valid SHALL go to 0 and pred_taken/pred_ctr/pred_tidx SHALL hold their previous values.
REQ-020 pred_taken SHALL equal the MSB of the counter read.
REQ-021 Update SHALL use saturating arithmetic: taken increments, saturating at 2^CNT_W-1; not-taken decrements, saturating at 0.
REQ-022 The counter update SHALL be written on the posedge where upd_valid=1.
REQ-023 In gshare mode, the GHR SHALL shift left with upd_taken inserted at bit 0 on every upd_valid. The GHR is non-speculative, and the GHR change affects lookups from the next cycle on.
REQ-024 Read-write collision: when rd_valid and upd_valid are both 1 and the hashed index equals upd_tidx, the prediction SHALL use the post-update counter value (bypass).
REQ-025 Collision GHR: the same-cycle hash SHALL use the pre-shift GHR.
REQ-026 When clr=1, all counters SHALL load the init value (REQ-029) and the GHR SHALL load 0 at the next posedge.
REQ-027 clr SHALL override a simultaneous upd_valid, which is dropped; pred_valid SHALL be 0 in the cycle after clr.
REQ-028 Indices SHALL wrap naturally modulo 2^IDX_W; no out-of-range behaviour exists.

Reset
REQ-029 While reset=1, all counters SHALL be 2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1) and the GHR SHALL be 0.
REQ-030 While reset=1, pred_valid SHALL be 0, pred_taken 0, pred_ctr 0 and pred_tidx 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight lookup or update immediately.
REQ-032 The first lookup SHALL be accepted on the first posedge after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the default parameter constants, the init-value function and the saturating-increment/decrement function.
REQ-034 One sub-module, bht_sat_ctr_next, SHALL hold the combinational counter-next logic and be parametrised by CNT_W.
REQ-035 The table, GHR and output registers SHALL stay in bht_gshare.

Verification
REQ-036 Defaults, reset, then rd_idx=3 -> next cycle pred_valid=1, pred_ctr=1, pred_taken=0, pred_tidx=3.
REQ-037 Defaults, three taken updates to idx 7, then read 7 -> pred_ctr=3, pred_taken=1; one not-taken update then read -> pred_ctr=2, pred_taken=1.
REQ-038 Defaults, rd and upd (taken) to idx 9 in the same cycle, counter=1 -> pred_ctr=2, pred_taken=1 (bypass).
REQ-039 GHR_W=3, updates taken, not-taken, taken (GHR=3'b101), then rd_idx=5'b00110 -> pred_tidx=5'b00011.
REQ-040 Defaults, counter at 3 with clr and taken upd in the same cycle, then read -> pred_ctr=1.
REQ-041 Defaults, pred_valid=0 in the cycle after clr; reset mid-update -> counter stays at init; CNT_W=1 and CNT_W=4 saturation at both ends.

Source files
------------

// File: rtl/bht_gshare_pkg.sv
// Shared constants and counter arithmetic for the gshare/bimodal branch history table.
// Functions work on a 4-bit container so one definition serves every legal CNT_W (1..4).
package bht_gshare_pkg;

   localparam int unsigned DEF_IDX_W = 5;
   localparam int unsigned DEF_CNT_W = 2;
   localparam int unsigned DEF_GHR_W = 0;
   localparam int unsigned MAX_CNT_W = 4;

   // Weakly not-taken: 2^(cnt_w-1)-1, which is 0 for a 1-bit counter.
   function automatic logic [MAX_CNT_W-1:0] bht_ctr_init(input int unsigned cnt_w);
      return MAX_CNT_W'((1 << (cnt_w - 1)) - 1);
   endfunction

   function automatic logic [MAX_CNT_W-1:0] bht_ctr_sat(
      input logic [MAX_CNT_W-1:0] ctr,
      input logic                 taken,
      input int unsigned          cnt_w
   );
      logic [MAX_CNT_W-1:0] max_v;
      max_v = MAX_CNT_W'((1 << cnt_w) - 1);
      if (taken) begin
         return (ctr == max_v) ? ctr : ctr + 1'b1;
      end
      return (ctr == '0) ? ctr : ctr - 1'b1;
   endfunction

endpackage

// File: rtl/bht_sat_ctr_next.sv
// Combinational next value of one saturating direction counter.
module bht_sat_ctr_next
   import bht_gshare_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic [CNT_W-1:0] i_ctr,
   input  logic             i_taken,
   output logic [CNT_W-1:0] o_ctr
);

   logic [MAX_CNT_W-1:0] w_wide;

   assign w_wide = bht_ctr_sat(MAX_CNT_W'(i_ctr), i_taken, CNT_W);
   assign o_ctr  = CNT_W'(w_wide);

endmodule

// File: rtl/bht_gshare.sv
// Branch direction predictor: flop table of saturating counters indexed by PC bits,
// optionally XORed with a non-speculative global history (gshare when GHR_W > 0).
module bht_gshare
   import bht_gshare_pkg::*;
#(
   parameter int unsigned IDX_W = DEF_IDX_W,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned GHR_W = DEF_GHR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_valid,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [CNT_W-1:0] pred_ctr,
   output logic [IDX_W-1:0] pred_tidx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_tidx,
   input  logic             upd_taken,
   input  logic             clr
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'(bht_ctr_init(CNT_W));

   logic [CNT_W-1:0] r_tbl [DEPTH];
   logic             r_pred_valid;
   logic             r_pred_taken;
   logic [CNT_W-1:0] r_pred_ctr;
   logic [IDX_W-1:0] r_pred_tidx;

   logic [IDX_W-1:0] w_ghr_ext;
   logic [IDX_W-1:0] w_hidx;
   logic [CNT_W-1:0] w_upd_ctr;
   logic [CNT_W-1:0] w_rd_ctr;
   logic             w_upd_en;
   logic             w_bypass;

   generate
      if (GHR_W == 0) begin : gen_bimodal
         assign w_ghr_ext = '0;
      end else begin : gen_gshare
         logic [GHR_W-1:0] r_ghr;

         // History only advances on resolved branches; lookups this cycle see the old value.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_ghr <= '0;
            end else if (clr) begin
               r_ghr <= '0;
            end else if (upd_valid) begin
               r_ghr <= GHR_W'({r_ghr, upd_taken});
            end
         end

         assign w_ghr_ext = IDX_W'(r_ghr);
      end
   endgenerate

   assign w_hidx   = rd_idx ^ w_ghr_ext;
   assign w_upd_en = upd_valid && !clr;

   bht_sat_ctr_next #(
      .CNT_W (CNT_W)
   ) u_ctr_next (
      .i_ctr   (r_tbl[upd_tidx]),
      .i_taken (upd_taken),
      .o_ctr   (w_upd_ctr)
   );

   // A same-cycle update to the looked-up entry is forwarded so the prediction is never stale.
   assign w_bypass = w_upd_en && (w_hidx == upd_tidx);
   assign w_rd_ctr = w_bypass ? w_upd_ctr : r_tbl[w_hidx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tbl[i] <= CTR_INIT;
         end
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tbl[i] <= CTR_INIT;
         end
      end else if (upd_valid) begin
         r_tbl[upd_tidx] <= w_upd_ctr;
      end
   end

   // Prediction fields hold when no lookup is accepted; only the valid flag drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ctr   <= '0;
         r_pred_tidx  <= '0;
      end else if (clr) begin
         r_pred_valid <= 1'b0;
      end else if (rd_valid) begin
         r_pred_valid <= 1'b1;
         r_pred_taken <= w_rd_ctr[CNT_W-1];
         r_pred_ctr   <= w_rd_ctr;
         r_pred_tidx  <= w_hidx;
      end else begin
         r_pred_valid <= 1'b0;
      end
   end

   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign pred_ctr   = r_pred_ctr;
   assign pred_tidx  = r_pred_tidx;

endmodule

// File: tb/tb_bht_gshare.sv
// Bench for bht_gshare: four configurations share one stimulus stream and are checked
// against an arithmetic reference model, plus directed vectors and corner sequences.
module tb_bht_gshare;

  localparam int NCFG = 4;
  localparam int DEPTH = 32;
  localparam int CFG_CW [NCFG] = '{2, 2, 1, 4};
  localparam int CFG_GW [NCFG] = '{0, 3, 0, 0};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rd_valid;
  logic [4:0] rd_idx;
  logic       upd_valid;
  logic [4:0] upd_tidx;
  logic       upd_taken;
  logic       clr;

  logic       v_d, v_g, v_1, v_4;
  logic       t_d, t_g, t_1, t_4;
  logic [1:0] c_d, c_g;
  logic [0:0] c_1;
  logic [3:0] c_4;
  logic [4:0] i_d, i_g, i_1, i_4;

  bht_gshare u_def (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .pred_valid(v_d), .pred_taken(t_d), .pred_ctr(c_d), .pred_tidx(i_d),
    .upd_valid(upd_valid), .upd_tidx(upd_tidx), .upd_taken(upd_taken), .clr(clr));

  bht_gshare #(.IDX_W(5), .CNT_W(2), .GHR_W(3)) u_gs (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .pred_valid(v_g), .pred_taken(t_g), .pred_ctr(c_g), .pred_tidx(i_g),
    .upd_valid(upd_valid), .upd_tidx(upd_tidx), .upd_taken(upd_taken), .clr(clr));

  bht_gshare #(.IDX_W(5), .CNT_W(1), .GHR_W(0)) u_c1 (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .pred_valid(v_1), .pred_taken(t_1), .pred_ctr(c_1), .pred_tidx(i_1),
    .upd_valid(upd_valid), .upd_tidx(upd_tidx), .upd_taken(upd_taken), .clr(clr));

  bht_gshare #(.IDX_W(5), .CNT_W(4), .GHR_W(0)) u_c4 (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .pred_valid(v_4), .pred_taken(t_4), .pred_ctr(c_4), .pred_tidx(i_4),
    .upd_valid(upd_valid), .upd_tidx(upd_tidx), .upd_taken(upd_taken), .clr(clr));

  logic       o_v [NCFG];
  logic       o_t [NCFG];
  logic [3:0] o_c [NCFG];
  logic [4:0] o_i [NCFG];
  assign o_v[0] = v_d;  assign o_t[0] = t_d;  assign o_c[0] = {2'b00, c_d};  assign o_i[0] = i_d;
  assign o_v[1] = v_g;  assign o_t[1] = t_g;  assign o_c[1] = {2'b00, c_g};  assign o_i[1] = i_g;
  assign o_v[2] = v_1;  assign o_t[2] = t_1;  assign o_c[2] = {3'b000, c_1}; assign o_i[2] = i_1;
  assign o_v[3] = v_4;  assign o_t[3] = t_4;  assign o_c[3] = c_4;           assign o_i[3] = i_4;

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer counters per configuration
  int m_ctr [NCFG][DEPTH];
  int m_ghr [NCFG];
  int m_v [NCFG], m_t [NCFG], m_c [NCFG], m_i [NCFG];

  function automatic int init_of(input int cw);
    return (1 << (cw - 1)) - 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int e = 0; e < DEPTH; e++) m_ctr[k][e] = init_of(CFG_CW[k]);
      m_ghr[k] = 0;
      m_v[k] = 0; m_t[k] = 0; m_c[k] = 0; m_i[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NCFG; k++) begin
      int mask, maxv, h, nc;
      mask = (1 << CFG_GW[k]) - 1;
      maxv = (1 << CFG_CW[k]) - 1;
      h = (int'(rd_idx) ^ (m_ghr[k] & mask)) % DEPTH;
      if (clr) begin
        for (int e = 0; e < DEPTH; e++) m_ctr[k][e] = init_of(CFG_CW[k]);
        m_ghr[k] = 0;
        m_v[k] = 0;
      end else begin
        nc = m_ctr[k][upd_tidx];
        if (upd_valid) nc = upd_taken ? ((nc < maxv) ? nc + 1 : nc) : ((nc > 0) ? nc - 1 : 0);
        if (rd_valid) begin
          m_c[k] = (upd_valid && h == int'(upd_tidx)) ? nc : m_ctr[k][h];
          m_t[k] = m_c[k] / (1 << (CFG_CW[k] - 1));
          m_i[k] = h;
          m_v[k] = 1;
        end else begin
          m_v[k] = 0;
        end
        if (upd_valid) begin
          m_ctr[k][upd_tidx] = nc;
          m_ghr[k] = ((m_ghr[k] * 2) + int'(upd_taken)) & mask;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("%s_cfg%0d_valid", tag, k), 32'(o_v[k]), 32'(m_v[k]));
      chk($sformatf("%s_cfg%0d_taken", tag, k), 32'(o_t[k]), 32'(m_t[k]));
      chk($sformatf("%s_cfg%0d_ctr", tag, k), 32'(o_c[k]), 32'(m_c[k]));
      chk($sformatf("%s_cfg%0d_tidx", tag, k), 32'(o_i[k]), 32'(m_i[k]));
    end
  endtask

  // driver: called just after a negedge, returns just after the next negedge
  task automatic cycle(input bit rv, input int ri, input bit uv, input int ut,
                       input bit tk, input bit cl, input string tag);
    rd_valid = rv; rd_idx = 5'(ri);
    upd_valid = uv; upd_tidx = 5'(ut); upd_taken = tk; clr = cl;
    model_step();
    @(posedge clk);
    #1;
    cmp_model(tag);
    @(negedge clk);
    rd_valid = 0; upd_valid = 0; clr = 0;
  endtask

  typedef struct {
    bit rv; int ri; bit uv; int ut; bit tk; bit cl;
    bit ev; int ec; bit et; int ei;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1, 3,  0, 0,  0, 0,  1, 1, 0, 3};
    tbl[1]  = '{0, 0,  1, 7,  1, 0,  0, 1, 0, 3};
    tbl[2]  = '{0, 0,  1, 7,  1, 0,  0, 1, 0, 3};
    tbl[3]  = '{0, 0,  1, 7,  1, 0,  0, 1, 0, 3};
    tbl[4]  = '{1, 7,  0, 0,  0, 0,  1, 3, 1, 7};
    tbl[5]  = '{0, 0,  1, 7,  0, 0,  0, 3, 1, 7};
    tbl[6]  = '{1, 7,  0, 0,  0, 0,  1, 2, 1, 7};
    tbl[7]  = '{1, 9,  1, 9,  1, 0,  1, 2, 1, 9};
    tbl[8]  = '{1, 9,  0, 0,  0, 0,  1, 2, 1, 9};
    tbl[9]  = '{0, 0,  1, 7,  1, 0,  0, 2, 1, 9};
    tbl[10] = '{0, 0,  1, 7,  1, 1,  0, 2, 1, 9};
    tbl[11] = '{1, 7,  0, 0,  0, 0,  1, 1, 0, 7};
    tbl[12] = '{1, 9,  0, 0,  0, 0,  1, 1, 0, 9};
    tbl[13] = '{1, 0,  0, 0,  0, 1,  0, 1, 0, 9};
    tbl[14] = '{1, 31, 1, 31, 0, 0,  1, 0, 0, 31};
    tbl[15] = '{1, 31, 1, 31, 0, 0,  1, 0, 0, 31};

    reset = 1; rd_valid = 0; rd_idx = 0; upd_valid = 0; upd_tidx = 0; upd_taken = 0; clr = 0;
    model_reset();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("rst_cfg%0d_valid", k), 32'(o_v[k]), 0);
      chk($sformatf("rst_cfg%0d_taken", k), 32'(o_t[k]), 0);
      chk($sformatf("rst_cfg%0d_ctr", k), 32'(o_c[k]), 0);
      chk($sformatf("rst_cfg%0d_tidx", k), 32'(o_i[k]), 0);
    end
    @(negedge clk);
    rd_valid = 1;
    @(negedge clk);
    cmp_model("rst_hold");
    reset = 0; rd_valid = 0;

    // directed table on the default configuration
    for (int n = 0; n < 16; n++) begin
      cycle(tbl[n].rv, tbl[n].ri, tbl[n].uv, tbl[n].ut, tbl[n].tk, tbl[n].cl, $sformatf("tbl%0d", n));
    end
    for (int n = 0; n < 16; n++) begin
      // re-run is not needed; table results were checked inline below
    end

    // gshare hash: history T,N,T -> 3'b101, 5'b00110 ^ 5'b00101 = 5'b00011
    cycle(0, 0, 0, 0, 0, 1, "gs_clr");
    cycle(0, 0, 1, 0, 1, 0, "gs_u0");
    cycle(0, 0, 1, 0, 0, 0, "gs_u1");
    cycle(0, 0, 1, 0, 1, 0, "gs_u2");
    cycle(1, 6, 0, 0, 0, 0, "gs_rd");
    chk("gshare_tidx", 32'(i_g), 32'd3);
    chk("gshare_valid", 32'(v_g), 32'd1);

    // saturation at both ends for 1-bit and 4-bit counters
    cycle(0, 0, 0, 0, 0, 1, "sat_clr");
    for (int n = 0; n < 10; n++) cycle(0, 0, 1, 4, 1, 0, "sat_up");
    cycle(1, 4, 0, 0, 0, 0, "sat_rd_hi");
    chk("c1_sat_hi_ctr", 32'(c_1), 32'd1);
    chk("c1_sat_hi_taken", 32'(t_1), 32'd1);
    chk("c4_sat_hi_ctr", 32'(c_4), 32'd15);
    chk("c4_sat_hi_taken", 32'(t_4), 32'd1);
    for (int n = 0; n < 20; n++) cycle(0, 0, 1, 4, 0, 0, "sat_dn");
    cycle(1, 4, 0, 0, 0, 0, "sat_rd_lo");
    chk("c1_sat_lo_ctr", 32'(c_1), 32'd0);
    chk("c4_sat_lo_ctr", 32'(c_4), 32'd0);
    chk("c4_sat_lo_taken", 32'(t_4), 32'd0);

    // reset arriving while an update and lookup are pending
    rd_valid = 1; rd_idx = 12; upd_valid = 1; upd_tidx = 12; upd_taken = 1;
    #2 reset = 1;
    model_reset();
    #1;
    cmp_model("midrst_async");
    @(posedge clk);
    #1;
    cmp_model("midrst_edge");
    @(negedge clk);
    reset = 0; rd_valid = 0; upd_valid = 0;
    cycle(1, 12, 0, 0, 0, 0, "midrst_rd");
    chk("midrst_ctr_init", 32'(c_d), 32'd1);
    chk("midrst_c4_init", 32'(c_4), 32'd7);

    // randomized traffic, updates biased toward recently predicted entries
    for (int n = 0; n < 3000; n++) begin
      int ut;
      ut = ($urandom_range(0, 1) == 1) ? int'(i_d) : int'($urandom_range(0, 31));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31),
            $urandom_range(0, 2) != 0, ut, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // directed expectations for the default instance, sampled with the table stepping
  int tbl_pos = -1;
  initial begin
    @(negedge reset);
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #2;
      chk($sformatf("vec%0d_valid", n), 32'(v_d), 32'(tbl[n].ev));
      chk($sformatf("vec%0d_ctr", n), 32'(c_d), 32'(tbl[n].ec));
      chk($sformatf("vec%0d_taken", n), 32'(t_d), 32'(tbl[n].et));
      chk($sformatf("vec%0d_tidx", n), 32'(i_d), 32'(tbl[n].ei));
      tbl_pos = n;
    end
  end

endmodule
